opponent_bullet_ctl: RTL

//  Upstream control stage for the enemy-shell drawer. Launches one enemy shell on a fire request and

---
 rtl/opponent_bullet_ctl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/opponent_bullet_ctl.sv
// Enemy shell control: launch on fire, step per frame tick,
// detect tank/wall/edge hits, then hold flags and cool down.
module opponent_bullet_ctl #(
  parameter int BUL_SPEED       = 3,
  parameter int SCREEN_W        = 800,
  parameter int SCREEN_H        = 600,
  parameter int TANK_SIZE       = 40,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       fire_enemy,
  input  logic [2:0] dir_enemy_tank,
  input  logic [9:0] xpos_tank_enemy,
  input  logic [9:0] ypos_tank_enemy,
  input  logic [9:0] xpos_tank_us,
  input  logic [9:0] ypos_tank_us,
  input  logic       wall_hit,
  output logic [9:0] xpos_bullet_enemy,
  output logic [9:0] ypos_bullet_enemy,
  output logic [2:0] direction_from_enemy,
  output logic       tank_enemy_hit_us,
  output logic       obstacle_hit,
  output logic       busy
);

  localparam int CW =
    (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [10:0]   SPD     = 11'(BUL_SPEED);
  localparam logic [10:0]   X_MAX   = 11'(SCREEN_W - 1);
  localparam logic [10:0]   Y_MAX   = 11'(SCREEN_H - 1);
  localparam logic [10:0]   TSZ     = 11'(TANK_SIZE - 1);
  localparam logic [CW-1:0] CD_INIT = CW'(COOLDOWN_FRAMES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    HIT,
    COOL
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0]  x_n, y_n;
  logic [2:0]  dir_n;
  logic        th_n, oh_n, busy_n;

  logic [10:0] xe, ye, tx, ty, cx, cy;
  logic        in_bnd, on_tank;
  logic        t_hit, o_hit, mv;

  // Candidate move and hit detection, in 11 bits so nothing wraps
  always_comb begin
    xe     = {1'b0, xpos_bullet_enemy};
    ye     = {1'b0, ypos_bullet_enemy};
    tx     = {1'b0, xpos_tank_us};
    ty     = {1'b0, ypos_tank_us};
    cx     = xe;
    cy     = ye;
    in_bnd = 1'b0;
    unique case (direction_from_enemy)
      3'd1: begin
        cy     = ye - SPD;
        in_bnd = (ye >= SPD);
      end
      3'd2: begin
        cy     = ye + SPD;
        in_bnd = (cy <= Y_MAX);
      end
      3'd3: begin
        cx     = xe + SPD;
        in_bnd = (cx <= X_MAX);
      end
      3'd4: begin
        cx     = xe - SPD;
        in_bnd = (xe >= SPD);
      end
      default: in_bnd = 1'b0;
    endcase
    on_tank = (cx >= tx) && (cx <= tx + TSZ) &&
              (cy >= ty) && (cy <= ty + TSZ);
    t_hit = frame_tick && in_bnd && on_tank;
    o_hit = wall_hit || (frame_tick && !in_bnd);
    mv    = frame_tick && in_bnd;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = xpos_bullet_enemy;
    y_n     = ypos_bullet_enemy;
    dir_n   = direction_from_enemy;
    th_n    = tank_enemy_hit_us;
    oh_n    = obstacle_hit;
    busy_n  = busy;
    unique case (state)
      IDLE: begin
        if (fire_enemy &&
            (dir_enemy_tank inside {[3'd1:3'd4]})) begin
          x_n     = xpos_tank_enemy;
          y_n     = ypos_tank_enemy;
          dir_n   = dir_enemy_tank;
          busy_n  = 1'b1;
          state_n = FLY;
        end
      end
      FLY: begin
        // Tank hit outranks wall and edge hits
        priority case (1'b1)
          t_hit: begin
            x_n     = cx[9:0];
            y_n     = cy[9:0];
            th_n    = 1'b1;
            dir_n   = 3'd0;
            state_n = HIT;
          end
          o_hit: begin
            oh_n    = 1'b1;
            dir_n   = 3'd0;
            state_n = HIT;
          end
          mv: begin
            x_n = cx[9:0];
            y_n = cy[9:0];
          end
          default: ;
        endcase
      end
      HIT: begin
        if (frame_tick) begin
          th_n    = 1'b0;
          oh_n    = 1'b0;
          cnt_n   = CD_INIT;
          state_n = COOL;
        end
      end
      COOL: begin
        if (frame_tick) begin
          if (cnt <= CNT_ONE) begin
            cnt_n   = '0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      xpos_bullet_enemy    <= '0;
      ypos_bullet_enemy    <= '0;
      direction_from_enemy <= '0;
      tank_enemy_hit_us    <= 1'b0;
      obstacle_hit         <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_n;
      cnt                  <= cnt_n;
      xpos_bullet_enemy    <= x_n;
      ypos_bullet_enemy    <= y_n;
      direction_from_enemy <= dir_n;
      tank_enemy_hit_us    <= th_n;
      obstacle_hit         <= oh_n;
      busy                 <= busy_n;
    end
  end

endmodule
